// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment display path.
// The anode decoder and score formatter import the same definitions.
package display_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SCAN_W     = 3;
  localparam int DIGIT_W    = 4;

  // All digits blanked: the display stays dark until real contents commit.
  localparam logic [NUM_DIGITS-1:0] RESET_BLANK = 8'hFF;

  // One full display frame: eight BCD nibbles plus per-digit blank flags.
  typedef struct packed {
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [NUM_DIGITS-1:0]         blank;
  } frame_t;

  localparam frame_t RESET_FRAME = '{digits: '0, blank: RESET_BLANK};

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load/scan signal bundle between the score logic and the display scanner.
interface display_scan_ctrl_if;
  import display_scan_ctrl_pkg::*;

  logic                          load;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]         blank_in;
  logic [SCAN_W-1:0]             en;
  logic [DIGIT_W-1:0]            digit;
  logic                          blank;
  logic                          tick;
  logic                          frame_start;
  logic                          pending;

  // Master supplies new frames and watches the scan.
  modport master (
    output load, digits_in, blank_in,
    input  en, digit, blank, tick, frame_start, pending
  );

  // Slave is the scan controller itself.
  modport slave (
    input  load, digits_in, blank_in,
    output en, digit, blank, tick, frame_start, pending
  );

endinterface

// File: rtl/display_scan_ctrl_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_DIV clock cycles.
// Also reused by the game timer.
module tick_gen #(
  parameter int unsigned TICK_DIV = 125000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Count up and wrap to zero on the terminal count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Refresh scan controller: steps the digit index, double-buffers display
// contents and only swaps them in at a frame boundary so updates never tear.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 125000
) (
  input  logic                      clk,
  input  logic                      rst,
  display_scan_ctrl_if.slave        bus
);

  logic              tick;
  logic              frame_start;
  logic [SCAN_W-1:0] en_q, en_d;
  frame_t            act_q, act_d;
  frame_t            pend_q, pend_d;
  logic              pending_q, pending_d;
  logic [4:0]        nib_base;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_start = tick && (en_q == SCAN_W'(NUM_DIGITS - 1));
  assign nib_base    = {en_q, 2'b00};

  // Scan advance, commit at frame wrap, and capture of new frames; a load in
  // the commit cycle lands in the pending buffer after the old one moves out.
  always_comb begin
    en_d      = en_q;
    act_d     = act_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (tick) en_d = en_q + 1'b1;
    if (frame_start && pending_q) begin
      act_d     = pend_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      pend_d    = '{digits: bus.digits_in, blank: bus.blank_in};
      pending_d = 1'b1;
    end
  end

  // State registers; reset discards any pending frame and darkens the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= '0;
      act_q     <= RESET_FRAME;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      act_q     <= act_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
    end
  end

  assign bus.en          = en_q;
  assign bus.digit       = act_q.digits[nib_base +: DIGIT_W];
  assign bus.blank       = act_q.blank[en_q];
  assign bus.tick        = tick;
  assign bus.frame_start = frame_start;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with TICK_DIV=4.
// n counts clock edges since reset release; with TICK_DIV=4 the scan
// position after edge n is en=(n/4)%8 and tick is high when n%4==3.
module tb_display_scan_ctrl;

  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int fsCount = 0;

  logic [31:0] expDigits;
  logic [7:0]  expBlank;
  logic        expPend;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at n=%0d: got %0h, expected %0h", tag, n, observed, expected);
    end
  endtask

  task automatic checkAll();
    int  e;
    logic t;
    logic [3:0] d;
    e = (n / 4) % 8;
    t = ((n % 4) == 3);
    d = expDigits[4*e +: 4];
    checkOutput("en",          32'(bus.en),          32'(e));
    checkOutput("tick",        32'(bus.tick),        32'(t));
    checkOutput("frame_start", 32'(bus.frame_start), 32'(t && (e == 7)));
    checkOutput("digit",       32'(bus.digit),       32'(d));
    checkOutput("blank",       32'(bus.blank),       32'(expBlank[e]));
    checkOutput("pending",     32'(bus.pending),     32'(expPend));
    if (bus.frame_start === 1'b1) fsCount++;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    n++;
    checkAll();
  endtask

  task automatic runTo(input int target);
    while (n < target) stepCycle();
  endtask

  // One-cycle load strobe, expectations for the following edge set by caller.
  task automatic applyStimulus(input logic [31:0] digits, input logic [7:0] blank);
    bus.load      = 1'b1;
    bus.digits_in = digits;
    bus.blank_in  = blank;
    stepCycle();
    bus.load = 1'b0;
  endtask

  task automatic setDark();
    expDigits = 32'h0;
    expBlank  = 8'hFF;
    expPend   = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.load      = 1'b0;
    bus.digits_in = 32'h0;
    bus.blank_in  = 8'h0;
    setDark();

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1;
    n = 0;
    checkAll();
    rst = 1'b0;

    // Free-running scan: first tick after edge 3, frame wrap at edge 31.
    runTo(40);
    checkOutput("frame_start_count", 32'(fsCount), 32'd1);

    // Load mid-frame at en=2; commit happens on edge 64.
    expPend = 1'b1;
    applyStimulus(32'h8765_4321, 8'h00);
    runTo(63);
    expDigits = 32'h8765_4321;
    expBlank  = 8'h00;
    expPend   = 1'b0;
    runTo(70);

    // Two loads in one frame; only the second ever reaches the display.
    expPend = 1'b1;
    applyStimulus(32'h1111_1111, 8'h00);
    runTo(75);
    applyStimulus(32'h2222_2222, 8'h00);
    runTo(95);
    expDigits = 32'h2222_2222;
    expPend   = 1'b0;
    runTo(100);

    // Simultaneous load and commit on the frame_start cycle (n=127).
    expPend = 1'b1;
    applyStimulus(32'h5555_5555, 8'h00);
    runTo(127);
    checkOutput("fs_before_sim_load", 32'(bus.frame_start), 32'd1);
    expDigits = 32'h5555_5555;
    applyStimulus(32'hAAAA_AAAA, 8'h00);
    runTo(159);
    expDigits = 32'hAAAA_AAAA;
    expPend   = 1'b0;
    runTo(165);

    // Reset while a frame is pending and en=5; discarded data never shows.
    expPend = 1'b1;
    applyStimulus(32'h1234_5678, 8'h0F);
    runTo(181);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    setDark();
    checkAll();
    rst = 1'b0;
    runTo(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Refresh scan controller for the eight-digit seven-segment display. It divides the system clock into a scan tick and steps a 3-bit scan index `en` through digits 0..7. That index drives the downstream anode/decimal-point decoder. Alongside the index, the block presents the 4-bit BCD value and blank flag for the selected digit. New display contents are double-buffered and committed only at a frame boundary, so a score update never tears mid-scan.

## Interface
- `TICK_DIV`, default 125000: clock cycles per scan tick; 100 MHz / 125000 = 800 Hz tick, 100 Hz full-frame refresh. Legal range ≥ 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `load`  in  1  single-cycle strobe; captures `digits_in` and `blank_in` into the pending buffer.
- `digits_in`  in  32  eight BCD nibbles; nibble k = bits [4k+3:4k] = digit k.
- `blank_in`  in  8  bit k = 1 blanks digit k.
- `en`  out  3  scan index to the anode decoder (registered).
- `digit`  out  4  active-buffer nibble selected by `en`.
- `blank`  out  1  active-buffer blank bit selected by `en`.
- `tick`  out  1  one-cycle pulse when the scan advances.
- `frame_start`  out  1  one-cycle pulse on the tick that wraps `en` from 7 to 0.
- `pending`  out  1  a loaded frame is waiting for commit.

## Operation
- **Prescaler:** `cnt` runs 0..TICK_DIV-1 and wraps to 0. `tick` = (`cnt` == TICK_DIV-1), decoded combinationally from the register.
- **Scan:** on each edge with `tick`=1, `en` <= `en`+1 modulo 8; 7 wraps to 0. With no tick, `en` holds.
- `frame_start` = `tick` && (`en` == 7).
- **Pending buffer:** on `load`, `pend_digits` <= `digits_in`, `pend_blank` <= `blank_in`, and `pending` <= 1. A load while `pending`=1 overwrites the buffer; the last load wins.
- **Commit:** on an edge with `frame_start`=1 and `pending`=1, the active buffer <= pending buffer and `pending` <= 0. The first digit shown from the new contents is digit 0.
- **Load and commit in the same cycle:** the commit uses the old pending contents; the new load is captured and `pending` stays 1 for the next frame.
- **Outputs:** `digit` = `act_digits[4*en +: 4]` and `blank` = `act_blank[en]`, both combinational from registers. Non-BCD nibbles (A–F) pass through unchanged; the segment decoder handles them.

## Timing
- **Reset values:** `cnt`=0, `en`=0, `act_digits`=0, `act_blank`=8'hFF (display dark), pending buffer=0, `pending`=0. Hence `tick`=0, `frame_start`=0, `digit`=0, `blank`=1.
- **First tick:** the TICK_DIV-th cycle after reset deasserts. Ticks then repeat every TICK_DIV cycles.
- `en` changes on the edge that samples `tick`=1; `digit`/`blank` follow in the same cycle with no extra latency.
- **Load-to-display latency:** at most 8·TICK_DIV + 1 cycles. `pending` reads 1 from the cycle after `load` until the cycle after the commit edge.
- **Reset mid-frame:** returns to the reset state on the next edge. Any pending frame is discarded and the display goes dark until a new load commits.

## Structure
- **Shared package/header** holds `NUM_DIGITS`=8, `SCAN_W`=3, `DIGIT_W`=4, and the reset blank mask 8'hFF. The anode decoder and the score formatter use the same constants.
- **Sub-module:** `tick_gen` — parameterised prescaler with `clk`, `rst`, and output `tick`; reused by the game timer.
- **Top level:** holds the scan counter, the two buffers and the nibble mux.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset:** assert `rst` 3 cycles → `en`=0, `blank`=1, `pending`=0; first `tick` on the 4th cycle after release; `en` steps 0→1 on that edge.
- **Free-running scan:** 40 cycles → `en` sequence 0..7,0..1 with changes every 4 cycles; `frame_start` exactly once, when `en`=7 and `tick`=1.
- **Load and commit:** `load` with `digits_in`=32'h8765_4321, `blank_in`=8'h00 mid-frame → `pending`=1, display still dark. After the wrap, `en`=0 shows `digit`=1, then `en`=1 shows 2, …, `en`=7 shows 8; `pending`=0.
- **Overwrite:** two loads (32'h1111_1111 then 32'h2222_2222) within one frame → only 2s are ever displayed.
- **Simultaneous load and commit:** `load` 32'hAAAA_AAAA on the `frame_start` cycle while 32'h5555_5555 is pending → next frame shows 5s, `pending` stays 1, and the following frame shows As.
- **Reset mid-operation:** `rst` while `pending`=1 and `en`=5 → `en`=0, `pending`=0, `blank`=1; no later commit of the discarded data.
